conv4_feeder: RTL and testbench

//  Transmit side of the Conv4 core interface. Buffers incoming column beats into a
//  two-bank tile store, then streams each tile as ROW_LEN back-to-back element cycles
//  on four input-row lanes and three filter-row lanes with core_en high.

---
 rtl/conv4_feeder.sv | 163 ++++++++++++++++
 tb/tb_conv4_feeder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv4_feeder.sv
// Two-bank tile buffer feeding the Conv4 core: column beats in, ROW_LEN-cycle lane
// bursts out with core_en, and the core's two partial sums returned on a valid/ready port.
module conv4_feeder #(
    parameter int DW      = 8,
    parameter int ROW_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [7*DW-1:0] s_data,
    input  logic            s_last,
    output logic            core_en,
    output logic [DW-1:0]   o_r1,
    output logic [DW-1:0]   o_r2,
    output logic [DW-1:0]   o_r3,
    output logic [DW-1:0]   o_r4,
    output logic [DW-1:0]   o_f1,
    output logic [DW-1:0]   o_f2,
    output logic [DW-1:0]   o_f3,
    input  logic            core_end,
    input  logic [2*DW-1:0] core_sum1,
    input  logic [2*DW-1:0] core_sum2,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [2*DW-1:0] m_sum1,
    output logic [2*DW-1:0] m_sum2,
    output logic            err_len,
    output logic            err_timeout,
    output logic            busy
);

    localparam int CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [7*DW-1:0] bank_mem [2][ROW_LEN];

    logic [1:0]       state;
    logic [1:0]       full;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [TMO_W-1:0] tmo;
    logic             rdy_en;
    logic             wr_fire;
    logic             wr_last;
    logic             rd_last;
    logic [7*DW-1:0]  rd_word_p0;
    logic [7*DW-1:0]  lane_p1;

    // rdy_en keeps s_ready low through reset and for the reset edge itself
    assign s_ready    = rdy_en & ~full[wr_bank];
    assign wr_fire    = s_valid & s_ready;
    assign wr_last    = (wr_cnt == CNT_LAST);
    assign rd_last    = (rd_cnt == CNT_LAST);
    assign rd_word_p0 = bank_mem[rd_bank][rd_cnt];
    assign busy       = (state != ST_IDLE) | (|full);

    assign o_r1 = lane_p1[0*DW +: DW];
    assign o_r2 = lane_p1[1*DW +: DW];
    assign o_r3 = lane_p1[2*DW +: DW];
    assign o_r4 = lane_p1[3*DW +: DW];
    assign o_f1 = lane_p1[4*DW +: DW];
    assign o_f2 = lane_p1[5*DW +: DW];
    assign o_f3 = lane_p1[6*DW +: DW];

    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_fire && wr_last)
            full_set[wr_bank] = 1'b1;
        if (state == ST_STREAM && rd_last)
            full_clr[rd_bank] = 1'b1;
    end

    // Tile storage: plain RAM, contents are don't-care until the bank is marked full
    always_ff @(posedge clk) begin
        if (wr_fire)
            bank_mem[wr_bank][wr_cnt] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdy_en      <= 1'b0;
            state       <= ST_IDLE;
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            tmo         <= '0;
            core_en     <= 1'b0;
            lane_p1     <= '0;
            m_valid     <= 1'b0;
            m_sum1      <= '0;
            m_sum2      <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            full    <= (full & ~full_clr) | full_set;
            core_en <= 1'b0;

            if (wr_fire) begin
                if (s_last != wr_last)
                    err_len <= 1'b1;
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end

            if (m_valid && m_ready)
                m_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    rd_cnt <= '0;
                    if (full[rd_bank] && !m_valid)
                        state <= ST_STREAM;
                end
                // Stream stage: lanes and core_en are registered one cycle behind rd_cnt
                ST_STREAM: begin
                    lane_p1 <= rd_word_p0;
                    core_en <= 1'b1;
                    rd_cnt  <= rd_cnt + CNT_W'(1);
                    if (rd_last) begin
                        rd_bank <= ~rd_bank;
                        tmo     <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_end) begin
                        m_sum1  <= core_sum1;
                        m_sum2  <= core_sum2;
                        m_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (tmo == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv4_feeder.sv
// Directed bench for conv4_feeder (ROW_LEN=4, DW=8, TIMEOUT=8) with a small core responder.
module tb_conv4_feeder;

    localparam int DW  = 8;
    localparam int RL  = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [55:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        core_en;
    logic [7:0]  o_r1, o_r2, o_r3, o_r4, o_f1, o_f2, o_f3;
    logic        core_end = 1'b0;
    logic [15:0] core_sum1 = 16'hDEAD;
    logic [15:0] core_sum2 = 16'hBEEF;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_sum1, m_sum2;
    logic        err_len, err_timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    conv4_feeder #(.DW(DW), .ROW_LEN(RL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .core_en(core_en), .o_r1(o_r1), .o_r2(o_r2), .o_r3(o_r3), .o_r4(o_r4),
        .o_f1(o_f1), .o_f2(o_f2), .o_f3(o_f3), .core_end(core_end), .core_sum1(core_sum1),
        .core_sum2(core_sum2), .m_valid(m_valid), .m_ready(m_ready), .m_sum1(m_sum1),
        .m_sum2(m_sum2), .err_len(err_len), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Beat i of tile t: r1 = 4t+i+1, f1 = 0x10+4t+i, other lanes offset so every lane differs
    function automatic logic [55:0] beat(input int t, input int i);
        logic [7:0] r1, f1;
        r1 = 8'(t * 4 + i + 1);
        f1 = 8'(16 + t * 4 + i);
        return {8'(f1 + 8'hA0), 8'(f1 + 8'h80), f1, 8'(r1 + 8'h60), 8'(r1 + 8'h40), 8'(r1 + 8'h20), r1};
    endfunction

    function automatic logic [31:0] sums(input int idx);
        return {16'(16'h1100 + idx), 16'(16'hF0F0 - idx)};
    endfunction

    // Observation of lane bursts, burst lengths and accepted results
    logic [55:0] stream_q[$];
    int          runs_q[$];
    logic [31:0] res_q[$];
    int          run_len = 0;
    int          ovl_cnt = 0;

    always @(negedge clk) begin
        if (core_en === 1'b1) begin
            stream_q.push_back({o_f3, o_f2, o_f1, o_r4, o_r3, o_r2, o_r1});
            run_len++;
        end else if (run_len > 0) begin
            runs_q.push_back(run_len);
            run_len = 0;
        end
        if (core_en === 1'b1 && m_valid === 1'b1) ovl_cnt++;
        if (m_valid === 1'b1 && m_ready === 1'b1) res_q.push_back({m_sum1, m_sum2});
    end

    // Core model: pulses core_end with sums(resp_idx) a fixed delay after core_en falls
    bit   auto_end = 1'b0;
    int   end_delay = 1;
    int   resp_cnt = 0;
    int   resp_idx = 0;
    logic en_prev = 1'b0;

    always @(negedge clk) begin
        core_end  = 1'b0;
        core_sum1 = 16'hDEAD;
        core_sum2 = 16'hBEEF;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && auto_end) begin
                core_end = 1'b1;
                {core_sum1, core_sum2} = sums(resp_idx);
                resp_idx++;
            end
        end
        if (auto_end && en_prev === 1'b1 && core_en !== 1'b1) resp_cnt = end_delay + 1;
        en_prev = core_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [55:0] d, input logic last, output bit waited, output bit to);
        int n;
        n = 0; waited = 1'b0; to = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = last;
        while (s_ready !== 1'b1 && n < 100) begin waited = 1'b1; tick(); n++; end
        if (s_ready !== 1'b1) to = 1'b1;
        else tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic push_tile(input int t, input int last_i, inout int waits, inout int tos);
        bit w, to;
        for (int i = 0; i < RL; i++) begin
            push(beat(t, i), (i == last_i), w, to);
            waits += int'(w);
            tos += int'(to);
        end
    endtask

    task automatic wait_mvalid(output bit ok);
        int n;
        n = 0;
        while (m_valid !== 1'b1 && n < 100) begin tick(); n++; end
        ok = (m_valid === 1'b1);
    endtask

    task automatic do_reset();
        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; auto_end = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();
        auto_end = 1'b1; end_delay = 1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (core_en !== 1'b0) begin n_bad++; $display("FAIL rst_core_en: got %b want 0", core_en); end
        n_cmp++; if ({o_f3, o_f2, o_f1, o_r4, o_r3, o_r2, o_r1} !== 56'h0) begin n_bad++; $display("FAIL rst_lanes: got %h want 0", {o_f3, o_f2, o_f1, o_r4, o_r3, o_r2, o_r1}); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if ({m_sum1, m_sum2} !== 32'h0) begin n_bad++; $display("FAIL rst_m_sum: got %h want 0", {m_sum1, m_sum2}); end
        n_cmp++; if ({err_len, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", {err_len, err_timeout}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        rstn = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_before_edge: got %b want 0", s_ready); end
        tick();
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after_edge: got %b want 1", s_ready); end
    endtask

    task automatic test_basic();
        int sb, rb, qb, ib, waits, tos, got_r;
        bit ok;
        logic [55:0] got;
        do_reset();
        sb = stream_q.size(); rb = runs_q.size(); qb = res_q.size(); ib = resp_idx;
        waits = 0; tos = 0;
        push_tile(0, RL - 1, waits, tos);
        wait_mvalid(ok);
        n_cmp++; if (tos !== 0 || ok !== 1'b1) begin n_bad++; $display("FAIL basic_progress: got push_to=%0d mvalid_ok=%0d want 0/1", tos, ok); end
        got_r = (runs_q.size() > rb) ? runs_q[rb] : -1;
        n_cmp++; if (got_r !== RL) begin n_bad++; $display("FAIL basic_en_len: got %0d want %0d", got_r, RL); end
        for (int i = 0; i < RL; i++) begin
            got = (stream_q.size() > sb + i) ? stream_q[sb + i] : 'x;
            n_cmp++; if (got !== beat(0, i)) begin n_bad++; $display("FAIL basic_lane%0d: got %h want %h", i, got, beat(0, i)); end
        end
        n_cmp++; if ({m_sum1, m_sum2} !== sums(ib)) begin n_bad++; $display("FAIL basic_sums: got %h want %h", {m_sum1, m_sum2}, sums(ib)); end
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL basic_err_len: got %b want 0", err_len); end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_m_taken: got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        n_cmp++; if (res_q.size() !== qb + 1) begin n_bad++; $display("FAIL basic_res_count: got %0d want %0d", res_q.size() - qb, 1); end
    endtask

    task automatic test_back_to_back();
        int sb, rb, qb, ib, ob, waits, tos, n;
        logic [55:0] got;
        logic [31:0] gr;
        do_reset();
        sb = stream_q.size(); rb = runs_q.size(); qb = res_q.size(); ib = resp_idx; ob = ovl_cnt;
        waits = 0; tos = 0; m_ready = 1'b1;
        push_tile(0, RL - 1, waits, tos);
        push_tile(1, RL - 1, waits, tos);
        n = 0;
        while (res_q.size() < qb + 2 && n < 100) begin tick(); n++; end
        m_ready = 1'b0;
        n_cmp++; if (waits !== 0 || tos !== 0) begin n_bad++; $display("FAIL b2b_s_ready: got waits=%0d to=%0d want 0/0", waits, tos); end
        for (int k = 0; k < 2; k++) begin
            gr = (res_q.size() > qb + k) ? res_q[qb + k] : 'x;
            n_cmp++; if (gr !== sums(ib + k)) begin n_bad++; $display("FAIL b2b_result%0d: got %h want %h", k, gr, sums(ib + k)); end
        end
        for (int i = 0; i < 2 * RL; i++) begin
            got = (stream_q.size() > sb + i) ? stream_q[sb + i] : 'x;
            n_cmp++; if (got !== beat(i / RL, i % RL)) begin n_bad++; $display("FAIL b2b_lane%0d: got %h want %h", i, got, beat(i / RL, i % RL)); end
        end
        n_cmp++; if (runs_q.size() - rb !== 2) begin n_bad++; $display("FAIL b2b_bursts: got %0d want 2", runs_q.size() - rb); end
        n_cmp++; if (ovl_cnt - ob !== 0) begin n_bad++; $display("FAIL b2b_en_with_mvalid: got %0d want 0", ovl_cnt - ob); end
    endtask

    task automatic test_result_stall();
        int sb, ib, waits, tos, en_seen, chg, n;
        bit ok;
        logic [31:0] held;
        logic [55:0] got;
        do_reset();
        sb = stream_q.size(); ib = resp_idx;
        waits = 0; tos = 0;
        push_tile(0, RL - 1, waits, tos);
        push_tile(1, RL - 1, waits, tos);
        wait_mvalid(ok);
        held = {m_sum1, m_sum2};
        en_seen = 0; chg = 0;
        repeat (20) begin
            tick();
            if (core_en === 1'b1) en_seen++;
            if ({m_sum1, m_sum2} !== held) chg++;
        end
        n_cmp++; if (en_seen !== 0) begin n_bad++; $display("FAIL stall_core_en: got %0d cycles want 0", en_seen); end
        n_cmp++; if (chg !== 0) begin n_bad++; $display("FAIL stall_sum_stable: got %0d changes want 0", chg); end
        n_cmp++; if ({m_valid, m_sum1, m_sum2} !== {1'b1, sums(ib)}) begin n_bad++; $display("FAIL stall_result: got %h want %h", {m_valid, m_sum1, m_sum2}, {1'b1, sums(ib)}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", busy); end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        n = 0;
        while (core_en !== 1'b1 && n < 10) begin tick(); n++; end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL stall_restart_delay: got %0d want 2", n); end
        wait_mvalid(ok);
        n_cmp++; if ({m_valid, m_sum1, m_sum2} !== {1'b1, sums(ib + 1)}) begin n_bad++; $display("FAIL stall_result2: got %h want %h", {m_valid, m_sum1, m_sum2}, {1'b1, sums(ib + 1)}); end
        for (int i = 0; i < RL; i++) begin
            got = (stream_q.size() > sb + RL + i) ? stream_q[sb + RL + i] : 'x;
            n_cmp++; if (got !== beat(1, i)) begin n_bad++; $display("FAIL stall_tile2_lane%0d: got %h want %h", i, got, beat(1, i)); end
        end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    task automatic test_banks_full();
        int sb, qb, ib, waits, tos, rdy_seen, n;
        bit ok, w, to;
        logic [55:0] got;
        logic [31:0] gr;
        do_reset();
        sb = stream_q.size(); qb = res_q.size(); ib = resp_idx;
        waits = 0; tos = 0;
        push_tile(0, RL - 1, waits, tos);
        wait_mvalid(ok);
        push_tile(1, RL - 1, waits, tos);
        push_tile(2, RL - 1, waits, tos);
        n_cmp++; if (waits !== 0 || tos !== 0) begin n_bad++; $display("FAIL full_fill: got waits=%0d to=%0d want 0/0", waits, tos); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
        s_valid = 1'b1; s_data = beat(3, 0); s_last = 1'b0;
        rdy_seen = 0;
        repeat (5) begin tick(); if (s_ready === 1'b1) rdy_seen++; end
        n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL full_hold_ready: got %0d cycles want 0", rdy_seen); end
        m_ready = 1'b1;
        push(beat(3, 0), 1'b0, w, to);
        n_cmp++; if ({w, to} !== 2'b10) begin n_bad++; $display("FAIL full_ninth_beat: got waited=%b to=%b want 1/0", w, to); end
        for (int i = 1; i < RL; i++) begin
            push(beat(3, i), (i == RL - 1), w, to);
            tos += int'(to);
        end
        n = 0;
        while (res_q.size() < qb + 4 && n < 200) begin tick(); n++; end
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gr = (res_q.size() > qb + k) ? res_q[qb + k] : 'x;
            n_cmp++; if (gr !== sums(ib + k)) begin n_bad++; $display("FAIL full_result%0d: got %h want %h", k, gr, sums(ib + k)); end
        end
        for (int i = 0; i < 4 * RL; i++) begin
            got = (stream_q.size() > sb + i) ? stream_q[sb + i] : 'x;
            n_cmp++; if (got !== beat(i / RL, i % RL)) begin n_bad++; $display("FAIL full_lane%0d: got %h want %h", i, got, beat(i / RL, i % RL)); end
        end
    endtask

    task automatic test_timeout_len();
        int rb, qb, n, got_r;
        bit w, to;
        do_reset();
        auto_end = 1'b0;
        rb = runs_q.size(); qb = res_q.size();
        push(beat(0, 0), 1'b0, w, to);
        push(beat(0, 1), 1'b0, w, to);
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL tmo_err_len_early: got %b want 0", err_len); end
        push(beat(0, 2), 1'b1, w, to);
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL tmo_err_len_set: got %b want 1", err_len); end
        push(beat(0, 3), 1'b0, w, to);
        n = 0;
        while (core_en !== 1'b1 && n < 20) begin tick(); n++; end
        while (core_en !== 1'b0 && n < 40) begin tick(); n++; end
        n_cmp++; if (core_en !== 1'b0 || n >= 40) begin n_bad++; $display("FAIL tmo_stream_done: got core_en=%b after %0d cycles want 0", core_en, n); end
        repeat (5) tick();
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", err_timeout); end
        repeat (6) tick();
        n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_set: got %b want 1", err_timeout); end
        n_cmp++; if (m_valid !== 1'b0 || res_q.size() !== qb) begin n_bad++; $display("FAIL tmo_no_result: got m_valid=%b results=%0d want 0/0", m_valid, res_q.size() - qb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
        got_r = (runs_q.size() > rb) ? runs_q[rb] : -1;
        n_cmp++; if (got_r !== RL) begin n_bad++; $display("FAIL tmo_count_framing: got %0d want %0d", got_r, RL); end
        auto_end = 1'b1;
    endtask

    task automatic test_reset_mid_stream();
        int sb, ib, waits, tos, n;
        bit ok;
        logic [55:0] got;
        do_reset();
        waits = 0; tos = 0;
        m_ready = 1'b1;
        push_tile(7, RL - 2, waits, tos);
        wait_mvalid(ok);
        tick();
        push_tile(8, RL - 1, waits, tos);
        n = 0;
        while (core_en !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        n_cmp++; if ({core_en, err_len} !== 2'b11) begin n_bad++; $display("FAIL mid_precond: got core_en,err_len=%b want 11", {core_en, err_len}); end
        auto_end = 1'b0;
        rstn = 1'b0;
        tick();
        n_cmp++; if ({core_en, m_valid, s_ready, busy, err_len, err_timeout} !== 6'b0) begin n_bad++; $display("FAIL mid_rst_ctrl: got %b want 000000", {core_en, m_valid, s_ready, busy, err_len, err_timeout}); end
        n_cmp++; if ({o_f3, o_f2, o_f1, o_r4, o_r3, o_r2, o_r1} !== 56'h0) begin n_bad++; $display("FAIL mid_rst_lanes: got %h want 0", {o_f3, o_f2, o_f1, o_r4, o_r3, o_r2, o_r1}); end
        n_cmp++; if ({m_sum1, m_sum2} !== 32'h0) begin n_bad++; $display("FAIL mid_rst_sums: got %h want 0", {m_sum1, m_sum2}); end
        rstn = 1'b1;
        repeat (3) tick();
        auto_end = 1'b1;
        m_ready = 1'b0;
        sb = stream_q.size(); ib = resp_idx;
        push_tile(5, RL - 1, waits, tos);
        wait_mvalid(ok);
        for (int i = 0; i < RL; i++) begin
            got = (stream_q.size() > sb + i) ? stream_q[sb + i] : 'x;
            n_cmp++; if (got !== beat(5, i)) begin n_bad++; $display("FAIL mid_fresh_lane%0d: got %h want %h", i, got, beat(5, i)); end
        end
        n_cmp++; if ({m_valid, m_sum1, m_sum2} !== {1'b1, sums(ib)}) begin n_bad++; $display("FAIL mid_fresh_result: got %h want %h", {m_valid, m_sum1, m_sum2}, {1'b1, sums(ib)}); end
        n_cmp++; if ({err_len, err_timeout, busy} !== 3'b000) begin n_bad++; $display("FAIL mid_fresh_flags: got %b want 000", {err_len, err_timeout, busy}); end
        n_cmp++; if (tos !== 0) begin n_bad++; $display("FAIL mid_push_timeout: got %0d want 0", tos); end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_result_stall();
        test_banks_full();
        test_timeout_len();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
